// File: rtl/flash_attn_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// flash_attn_rd_ctrl_if
// Bundles every signal of the O-BRAM read controller except clock and reset.
//   Attention core port : I_ATTN_DONE, I_ATTN_ENA, I_ATTN_LINE, I_ATTN_COL
//   Manual read port    : I_MAN_EN, I_MAN_LINE, I_MAN_COL, O_MAN_VLD
//   Readout control     : I_START_RD, O_BUSY, O_RD_DONE
//   O-BRAM port         : O_BRAM_ENA, O_BRAM_LINE, O_BRAM_COL,
//                         I_BRAM_VLD, I_BRAM_TILE
//   Output stream       : O_TVALID, I_TREADY, O_TDATA, O_TLAST, O_TUSER
// The slave modport belongs to the controller; master is the surrounding
// system (core, BRAM and stream sink).
// ---------------------------------------------------------------------------
interface flash_attn_rd_ctrl_if #(
    parameter int D_W    = 16,
    parameter int TILE   = 16,
    parameter int N_LINE = 64,
    parameter int N_COL  = 8,
    parameter int OUT_W  = 256
);
    localparam int LW = $clog2(N_LINE);
    localparam int CW = $clog2(N_COL);
    localparam int TW = TILE * TILE * D_W;

    logic          I_ATTN_DONE;
    logic          I_ATTN_ENA;
    logic [LW-1:0] I_ATTN_LINE;
    logic [CW-1:0] I_ATTN_COL;
    logic          I_MAN_EN;
    logic [LW-1:0] I_MAN_LINE;
    logic [CW-1:0] I_MAN_COL;
    logic          I_START_RD;
    logic          O_BRAM_ENA;
    logic [LW-1:0] O_BRAM_LINE;
    logic [CW-1:0] O_BRAM_COL;
    logic          I_BRAM_VLD;
    logic [TW-1:0] I_BRAM_TILE;
    logic          O_MAN_VLD;
    logic          O_TVALID;
    logic          I_TREADY;
    logic [OUT_W-1:0]   O_TDATA;
    logic               O_TLAST;
    logic [LW+CW-1:0]   O_TUSER;
    logic          O_BUSY;
    logic          O_RD_DONE;

    modport slave (
        input  I_ATTN_DONE, I_ATTN_ENA, I_ATTN_LINE, I_ATTN_COL,
        input  I_MAN_EN, I_MAN_LINE, I_MAN_COL, I_START_RD,
        input  I_BRAM_VLD, I_BRAM_TILE, I_TREADY,
        output O_BRAM_ENA, O_BRAM_LINE, O_BRAM_COL, O_MAN_VLD,
        output O_TVALID, O_TDATA, O_TLAST, O_TUSER, O_BUSY, O_RD_DONE
    );

    modport master (
        output I_ATTN_DONE, I_ATTN_ENA, I_ATTN_LINE, I_ATTN_COL,
        output I_MAN_EN, I_MAN_LINE, I_MAN_COL, I_START_RD,
        output I_BRAM_VLD, I_BRAM_TILE, I_TREADY,
        input  O_BRAM_ENA, O_BRAM_LINE, O_BRAM_COL, O_MAN_VLD,
        input  O_TVALID, O_TDATA, O_TLAST, O_TUSER, O_BUSY, O_RD_DONE
    );
endinterface

// File: rtl/flash_attn_rd_ctrl.sv
// ---------------------------------------------------------------------------
// flash_attn_rd_ctrl
// Output-BRAM read controller for the flash-attention top. Shares the O-BRAM
// read port between the attention core (while I_ATTN_DONE=0), a manual
// single-tile read port (done and engine idle) and an autonomous readout
// engine that walks every tile and streams it as OUT_W-bit beats.
//
// Ports:
//   I_CLK  clock
//   I_RST  asynchronous active-high reset
//   bus    flash_attn_rd_ctrl_if.slave (BRAM port, requesters, stream)
//
// Build option: FA_RD_COL_MAJOR_EN selects column-major tile traversal
// (line index fastest); default is row-major (column index fastest).
// ---------------------------------------------------------------------------
module flash_attn_rd_ctrl #(
    parameter int D_W    = 16,
    parameter int TILE   = 16,
    parameter int N_LINE = 64,
    parameter int N_COL  = 8,
    parameter int OUT_W  = 256
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    flash_attn_rd_ctrl_if.slave  bus
);
    localparam int LW    = $clog2(N_LINE);
    localparam int CW    = $clog2(N_COL);
    localparam int TW    = TILE * TILE * D_W;
    localparam int BEATS = TW / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [LW-1:0] LAST_LINE = LW'(N_LINE - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(N_COL - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STREAM, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [LW-1:0] r_line;
    logic [CW-1:0] r_col;
    logic [BW-1:0] r_beat;
    logic [TW-1:0] r_tile;
    logic          r_man_pend;

    logic w_idle, w_abort, w_accept, w_last_beat, w_last_tile;
    logic w_eng_ena, w_tvalid, w_done;

    assign w_idle      = (r_state == S_IDLE);
    // Losing I_ATTN_DONE while the engine owns the port means the O data is
    // no longer valid; abandon the readout without signalling completion.
    assign w_abort     = !w_idle && !bus.I_ATTN_DONE;
    assign w_accept    = (r_state == S_STREAM) && bus.I_TREADY;
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_last_tile = (r_line == LAST_LINE) && (r_col == LAST_COL);

    // State register
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.I_START_RD && bus.I_ATTN_DONE) w_next = S_ISSUE;
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT:   if (bus.I_BRAM_VLD) w_next = S_STREAM;
            S_STREAM: if (w_accept && w_last_beat) w_next = w_last_tile ? S_DONE : S_ISSUE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    // Output decode
    always_comb begin
        w_eng_ena = 1'b0;
        w_tvalid  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_ISSUE:  w_eng_ena = 1'b1;
            S_STREAM: w_tvalid  = 1'b1;
            S_DONE:   w_done    = 1'b1;
            default:  ;
        endcase
    end

    // Tile address and beat counters
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_line <= '0;
            r_col  <= '0;
            r_beat <= '0;
        end else if (w_abort || r_state == S_DONE) begin
            r_line <= '0;
            r_col  <= '0;
            r_beat <= '0;
        end else begin
            if (r_state == S_WAIT && bus.I_BRAM_VLD) r_beat <= '0;
            if (w_accept) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    // The last tile keeps its address; the DONE state clears it.
                    if (!w_last_tile) begin
`ifdef FA_RD_COL_MAJOR_EN
                        if (r_line == LAST_LINE) begin
                            r_line <= '0;
                            r_col  <= r_col + 1'b1;
                        end else begin
                            r_line <= r_line + 1'b1;
                        end
`else
                        if (r_col == LAST_COL) begin
                            r_col  <= '0;
                            r_line <= r_line + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
`endif
                    end
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    // Tile capture; pure data, so it carries no reset
    always_ff @(posedge I_CLK) begin
        if (r_state == S_WAIT && bus.I_BRAM_VLD) r_tile <= bus.I_BRAM_TILE;
    end

    // A manual read is remembered from request until its BRAM response so that
    // O_MAN_VLD tracks the BRAM latency and ignores the core's own reads.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST)                               r_man_pend <= 1'b0;
        else if (!(bus.I_ATTN_DONE && w_idle))   r_man_pend <= 1'b0;
        else if (bus.I_MAN_EN)                   r_man_pend <= 1'b1;
        else if (bus.I_BRAM_VLD)                 r_man_pend <= 1'b0;
    end

    assign bus.O_BRAM_ENA  = !bus.I_ATTN_DONE ? bus.I_ATTN_ENA  : (w_idle ? bus.I_MAN_EN   : w_eng_ena);
    assign bus.O_BRAM_LINE = !bus.I_ATTN_DONE ? bus.I_ATTN_LINE : (w_idle ? bus.I_MAN_LINE : r_line);
    assign bus.O_BRAM_COL  = !bus.I_ATTN_DONE ? bus.I_ATTN_COL  : (w_idle ? bus.I_MAN_COL  : r_col);

    assign bus.O_MAN_VLD = bus.I_BRAM_VLD && bus.I_ATTN_DONE && w_idle && r_man_pend;

    // Beat 0 is the most significant slice, i.e. row 0 of the tile. The data
    // bus is forced to zero outside STREAM because r_tile has no reset.
    assign bus.O_TVALID  = w_tvalid;
    assign bus.O_TDATA   = w_tvalid ? r_tile[(BEATS - 1 - int'(r_beat)) * OUT_W +: OUT_W] : '0;
    assign bus.O_TLAST   = w_tvalid && w_last_beat && w_last_tile;
    assign bus.O_TUSER   = {r_line, r_col};
    assign bus.O_BUSY    = !w_idle;
    assign bus.O_RD_DONE = w_done;
endmodule

// File: doc/flash_attn_rd_ctrl.md
Name: flash_attn_rd_ctrl

Overview:
- Output-BRAM read controller for the flash-attention top.
- Arbitrates the O-BRAM read port between three requesters:
  - the attention core, while computation runs;
  - a legacy manual single-tile read port;
  - an autonomous readout engine that, after attention completes, walks every TILE x TILE tile of O and streams it out as narrow beats with valid/ready backpressure.
- Parametrised in element width, tile size, BRAM geometry and stream width.

Parameters:
- D_W, 16, element width in bits.
- TILE, 16, tile edge; one BRAM word = TILE*TILE*D_W bits.
- N_LINE, 64, tile-lines in O BRAM; line index width LW = $clog2(N_LINE).
- N_COL, 8, tile-columns in O BRAM; column index width CW = $clog2(N_COL).
- OUT_W, 256, stream beat width. Must divide TILE*TILE*D_W. BEATS = TILE*TILE*D_W/OUT_W.

Ports:
- I_CLK, input, 1, clock.
- I_RST, input, 1, reset (see Behaviour).
- I_ATTN_DONE, input, 1, level; high once attention output is complete.
- I_ATTN_ENA, input, 1, core O-BRAM enable.
- I_ATTN_LINE, input, LW, core O-BRAM line select.
- I_ATTN_COL, input, CW, core O-BRAM column select.
- I_MAN_EN, input, 1, manual single-tile read request (pulse).
- I_MAN_LINE, input, LW, manual line select.
- I_MAN_COL, input, CW, manual column select.
- I_START_RD, input, 1, pulse; start full autonomous readout.
- O_BRAM_ENA, output, 1, O-BRAM enable.
- O_BRAM_LINE, output, LW, O-BRAM line select.
- O_BRAM_COL, output, CW, O-BRAM column select.
- I_BRAM_VLD, input, 1, O-BRAM read-data valid.
- I_BRAM_TILE, input, TILE*TILE*D_W, flattened tile; element [i][j] at bits ((TILE-1-i)*TILE+(TILE-1-j))*D_W +: D_W.
- O_MAN_VLD, output, 1, manual-read data valid (I_BRAM_VLD gated).
- O_TVALID, output, 1, stream beat valid.
- I_TREADY, input, 1, stream beat ready.
- O_TDATA, output, OUT_W, stream beat.
- O_TLAST, output, 1, last beat of the last tile.
- O_TUSER, output, LW+CW, {line,col} of the current tile.
- O_BUSY, output, 1, readout engine active.
- O_RD_DONE, output, 1, one-cycle pulse when readout completes.

Interface: one clock; reset is asynchronous and active-high (I_CLK, I_RST).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; line/col/beat counters 0.
- Port mux, combinational on the O_BRAM_* outputs:
  - I_ATTN_DONE=0: pass I_ATTN_*.
  - I_ATTN_DONE=1 and FSM=IDLE: pass I_MAN_*.
  - Otherwise: engine drives the port.
  - Manual requests while busy or during attention are dropped.
- O_MAN_VLD = I_BRAM_VLD & I_ATTN_DONE & (FSM==IDLE). Registered by one cycle alongside the request, so it tracks the BRAM response.
- FSM states: IDLE, ISSUE, WAIT, STREAM, DONE.
  - IDLE -> ISSUE on I_START_RD & I_ATTN_DONE. I_START_RD while busy or with I_ATTN_DONE=0 is ignored.
  - ISSUE: O_BRAM_ENA=1 for exactly one cycle with the current {line,col}; -> WAIT.
  - WAIT: on I_BRAM_VLD, latch I_BRAM_TILE into the tile register, beat=0; -> STREAM. No timeout.
  - STREAM: O_TVALID=1. O_TDATA = tile_reg[(BEATS-1-beat)*OUT_W +: OUT_W], so beat 0 carries row 0 first.
    - Beat advances only on O_TVALID & I_TREADY; O_TDATA/O_TUSER hold stable while stalled.
    - After beat BEATS-1 is accepted: if {line,col} is the last tile, -> DONE; else advance the address and -> ISSUE.
    - Address order: col increments fastest, wrap at N_COL-1 then line++; last tile = (N_LINE-1, N_COL-1).
  - DONE: O_RD_DONE=1 for one cycle; counters cleared; -> IDLE.
- O_TLAST = 1 only on beat BEATS-1 of the last tile.
- O_BUSY = 1 in ISSUE, WAIT, STREAM and DONE.
- I_ATTN_DONE falling while busy: abort to IDLE next cycle, drop O_TVALID, clear counters, no O_RD_DONE.
- I_RST mid-operation: immediate return to reset values; any partially streamed tile is discarded.
- Throughput: per tile, 1 (ISSUE) + BRAM latency + BEATS cycles, with I_TREADY held high.

Optional Feature:
- Macro: FA_RD_COL_MAJOR_EN.
- Defined: traversal is column-major. Line increments fastest, wraps at N_LINE-1 then col++. The last tile is still (N_LINE-1, N_COL-1), and O_TUSER reflects the same order.
- Undefined: row-major order as specified above.

Test Plan:
- Attention phase:
  - Stimulus: I_ATTN_DONE=0, I_ATTN_ENA=1, LINE=5, COL=3, and I_MAN_EN=1 with LINE=9.
  - Response: O_BRAM_ENA=1, LINE=5, COL=3; O_MAN_VLD stays 0.
- Manual read:
  - Stimulus: I_ATTN_DONE=1, IDLE, I_MAN_EN pulse with LINE=2, COL=7; model returns VLD 1 cycle later.
  - Response: O_BRAM_LINE=2, COL=7; O_MAN_VLD=1 for one cycle.
- Full readout, defaults, I_TREADY=1, tile t filled with element value t:
  - 512 tiles x 16 beats = 8192 beats.
  - O_TUSER order {0,0},{0,1}..{0,7},{1,0}..{63,7}; beat 0 of each tile = row 0.
  - O_TLAST only on beat 8191; O_RD_DONE one pulse; O_BUSY back to 0.
- Backpressure:
  - Stimulus: I_TREADY toggles 1,0,0,1 during tile {0,0}.
  - Response: O_TDATA/O_TUSER hold during the 0 cycles; no beat lost or duplicated; data matches the reference model.
- Abort and restart:
  - Stimulus: drop I_ATTN_DONE at beat 5 of tile {3,2}.
  - Response: IDLE next cycle, O_TVALID=0, no O_RD_DONE.
  - Re-raise I_ATTN_DONE, then I_START_RD: readout restarts at {0,0}.
- Reset mid-operation and column-major order:
  - Stimulus: assert I_RST in WAIT.
  - Response: all outputs 0 asynchronously.
  - With FA_RD_COL_MAJOR_EN defined, O_TUSER order is {0,0},{1,0}..{63,0},{0,1}.
